// File: rtl/ab_input_conditioner.sv
// Two-channel input conditioner: 2-flop synchronizer + debounce filter per channel.
// Define AB_PULSE_OUT_EN to turn a/b into one-cycle rising-edge pulses instead of levels.

module ab_ic_channel #(
   parameter int unsigned CNT_W           = 2,
   parameter int unsigned DEBOUNCE_CYCLES = 4,
   parameter logic        SYNC_INIT       = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic raw_i,
   output logic deb_o,
   output logic upd_o
);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             s1_q, s2_q, deb_q, deb_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Update fires on the edge that completes DEBOUNCE_CYCLES consecutive mismatches.
   assign upd_o = (s2_q != deb_q) && (cnt_q == CNT_MAX);
   assign deb_o = deb_q;

   always_comb begin
      cnt_d = cnt_q;
      deb_d = deb_q;
      if (s2_q == deb_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_MAX) begin
         deb_d = s2_q;
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_q  <= SYNC_INIT;
         s2_q  <= SYNC_INIT;
         deb_q <= SYNC_INIT;
         cnt_q <= '0;
      end else begin
         s1_q  <= raw_i;
         s2_q  <= s1_q;
         deb_q <= deb_d;
         cnt_q <= cnt_d;
      end
   end
endmodule

module ab_input_conditioner #(
   parameter int unsigned DEBOUNCE_CYCLES = 4,
   parameter logic        SYNC_INIT       = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic a_raw,
   input  logic b_raw,
   output logic a,
   output logic b,
   output logic chg
);
   localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;

   logic [1:0] raw, deb, upd;
   logic       chg_q;

   assign raw = {b_raw, a_raw};

   for (genvar c = 0; c < 2; c++) begin : g_ch
      ab_ic_channel #(
         .CNT_W          (CNT_W),
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
         .SYNC_INIT      (SYNC_INIT)
      ) u_ch (
         .clk  (clk),
         .reset(reset),
         .raw_i(raw[c]),
         .deb_o(deb[c]),
         .upd_o(upd[c])
      );
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) chg_q <= 1'b0;
      else       chg_q <= |upd;
   end
   assign chg = chg_q;

`ifdef AB_PULSE_OUT_EN
   logic a_q, b_q;

   // An update while deb is low is by construction a 0->1 rise.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         a_q <= 1'b0;
         b_q <= 1'b0;
      end else begin
         a_q <= upd[0] & ~deb[0];
         b_q <= upd[1] & ~deb[1];
      end
   end
   assign a = a_q;
   assign b = b_q;
`else
   assign a = deb[0];
   assign b = deb[1];
`endif
endmodule
